// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Turns the raw PS/2 set-2 byte stream coming out of an upstream receive FIFO
// into keyboard events {brk, ext, code[7:0]} and queues them in a small event
// FIFO.
// Handshakes:
//   upstream : the head byte is taken when kbd_ready=1 and the event FIFO has
//              room; kbd_nextdata_n is low for exactly one cycle per taken byte.
//   consumer : the head event transfers on a rising edge where evt_valid=1 and
//              evt_ready=1; evt_ready with evt_valid=0 is ignored.
// Optional feature: define PS2_DEC_ASCII_EN to build the set-2 to ASCII lookup
// on evt_ascii; otherwise evt_ascii is tied to 0x00.
// EVT_DEPTH must be a power of two between 2 and 16.

module ps2_scancode_decoder #(
  parameter int EVT_DEPTH = 4
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic [7:0] kbd_data,
  input  logic       kbd_ready,
  output logic       kbd_nextdata_n,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [9:0] evt_data,
  output logic [7:0] evt_ascii,
  output logic       err_overrun,
  output logic       dbg_state
);

  localparam int AW = $clog2(EVT_DEPTH);
  localparam logic [AW:0] FULL_CNT = EVT_DEPTH[AW:0];

  // Keyboard bytes with special meaning in set 2.
  localparam logic [7:0] B_EXT    = 8'hE0;
  localparam logic [7:0] B_BRK    = 8'hF0;
  localparam logic [7:0] B_PAUSE  = 8'hE1;
  localparam logic [7:0] B_ACK    = 8'hFA;
  localparam logic [7:0] B_BAT_OK = 8'hAA;
  localparam logic [7:0] B_ECHO   = 8'hEE;
  localparam logic [7:0] B_RESEND = 8'hFE;
  localparam logic [7:0] B_OVR0   = 8'h00;
  localparam logic [7:0] B_OVR1   = 8'hFF;

  // The pause key sends E1 followed by seven more bytes.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_POP  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic       nextdata_n_d;
  logic [7:0] byte_q;

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [2:0] pause_q, pause_d;
  logic       ovr_q, ovr_d;

  logic       push;
  logic [9:0] push_data;

  logic [9:0]    mem [EVT_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          fifo_full;
  logic          rd_en;

  assign fifo_full   = (count_q == FULL_CNT);
  assign evt_valid   = (count_q != '0);
  assign rd_en       = evt_valid & evt_ready;
  assign evt_data    = evt_valid ? mem[rd_ptr_q] : 10'h000;
  assign err_overrun = ovr_q;
  assign dbg_state   = state_q;

  // ---------------------------------------------------------------------------
  // Byte fetch FSM
  // ---------------------------------------------------------------------------

  // State register, registered pop strobe and captured byte.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q        <= S_IDLE;
      kbd_nextdata_n <= 1'b1;
      byte_q         <= 8'h00;
    end else begin
      state_q        <= state_d;
      kbd_nextdata_n <= nextdata_n_d;
      if (state_q == S_IDLE && state_d == S_POP) begin
        byte_q <= kbd_data;
      end
    end
  end

  // Next state: take a byte only when the event FIFO can absorb its result.
  always_comb begin
    state_d      = state_q;
    nextdata_n_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (kbd_ready && !fifo_full) begin
          state_d      = S_POP;
          nextdata_n_d = 1'b0;
        end
      end
      S_POP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Byte decode (evaluated during POP, committed on the POP->IDLE edge)
  // ---------------------------------------------------------------------------

  // Decode the captured byte against the prefix flags and pause counter.
  always_comb begin
    push      = 1'b0;
    push_data = 10'h000;
    ext_d     = ext_q;
    brk_d     = brk_q;
    pause_d   = pause_q;
    ovr_d     = ovr_q;
    if (state_q == S_POP) begin
      if (pause_q != 3'd0) begin
        // Inside the pause sequence: swallow bytes, report once at the end.
        pause_d = pause_q - 3'd1;
        if (pause_q == 3'd1) begin
          push      = 1'b1;
          push_data = {2'b00, B_PAUSE};
        end
      end else begin
        case (byte_q)
          B_PAUSE: pause_d = PAUSE_TAIL;
          B_EXT:   ext_d   = 1'b1;
          B_BRK:   brk_d   = 1'b1;
          B_OVR0, B_OVR1: ovr_d = 1'b1;
          B_ACK, B_BAT_OK, B_ECHO, B_RESEND: begin
            // Keyboard status bytes are only meaningful without a prefix;
            // after a prefix they are treated as ordinary key codes.
            if (ext_q || brk_q) begin
              push      = 1'b1;
              push_data = {brk_q, ext_q, byte_q};
              ext_d     = 1'b0;
              brk_d     = 1'b0;
            end
          end
          default: begin
            push      = 1'b1;
            push_data = {brk_q, ext_q, byte_q};
            ext_d     = 1'b0;
            brk_d     = 1'b0;
          end
        endcase
      end
    end
  end

  // Decoder state: prefix flags, pause counter and sticky overrun flag.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      pause_q <= 3'd0;
      ovr_q   <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      pause_q <= pause_d;
      ovr_q   <= ovr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------

  // Pointers and occupancy; pointers wrap naturally since depth is 2^AW.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Event storage; never read while empty, so it needs no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // ---------------------------------------------------------------------------
  // ASCII view of the head event
  // ---------------------------------------------------------------------------

`ifdef PS2_DEC_ASCII_EN
  logic [7:0] ascii;

  // Plain (no ext, no break) letters, digits, space and enter map to ASCII.
  always_comb begin
    ascii = 8'h00;
    if (evt_data[9:8] == 2'b00) begin
      case (evt_data[7:0])
        8'h1C: ascii = 8'h61; // a
        8'h32: ascii = 8'h62; // b
        8'h21: ascii = 8'h63; // c
        8'h23: ascii = 8'h64; // d
        8'h24: ascii = 8'h65; // e
        8'h2B: ascii = 8'h66; // f
        8'h34: ascii = 8'h67; // g
        8'h33: ascii = 8'h68; // h
        8'h43: ascii = 8'h69; // i
        8'h3B: ascii = 8'h6A; // j
        8'h42: ascii = 8'h6B; // k
        8'h4B: ascii = 8'h6C; // l
        8'h3A: ascii = 8'h6D; // m
        8'h31: ascii = 8'h6E; // n
        8'h44: ascii = 8'h6F; // o
        8'h4D: ascii = 8'h70; // p
        8'h15: ascii = 8'h71; // q
        8'h2D: ascii = 8'h72; // r
        8'h1B: ascii = 8'h73; // s
        8'h2C: ascii = 8'h74; // t
        8'h3C: ascii = 8'h75; // u
        8'h2A: ascii = 8'h76; // v
        8'h1D: ascii = 8'h77; // w
        8'h22: ascii = 8'h78; // x
        8'h35: ascii = 8'h79; // y
        8'h1A: ascii = 8'h7A; // z
        8'h45: ascii = 8'h30; // 0
        8'h16: ascii = 8'h31; // 1
        8'h1E: ascii = 8'h32; // 2
        8'h26: ascii = 8'h33; // 3
        8'h25: ascii = 8'h34; // 4
        8'h2E: ascii = 8'h35; // 5
        8'h36: ascii = 8'h36; // 6
        8'h3D: ascii = 8'h37; // 7
        8'h3E: ascii = 8'h38; // 8
        8'h46: ascii = 8'h39; // 9
        8'h29: ascii = 8'h20; // space
        8'h5A: ascii = 8'h0D; // enter
        default: ascii = 8'h00;
      endcase
    end
  end

  assign evt_ascii = ascii;
`else
  assign evt_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder
// Upstream receiver is modelled as a byte array with read/write indices; the
// bench pushes bytes and, in the same step, pushes the expected events into a
// scoreboard queue. A monitor pops and compares on every accepted event.

module tb_ps2_scancode_decoder;

  logic       clock = 1'b0;
  logic       clrn  = 1'b0;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_nextdata_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [9:0] evt_data;
  logic [7:0] evt_ascii;
  logic       err_overrun;
  logic       dbg_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  ps2_scancode_decoder #(.EVT_DEPTH(4)) dut (
    .clock          (clock),
    .clrn           (clrn),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_nextdata_n (kbd_nextdata_n),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_data       (evt_data),
    .evt_ascii      (evt_ascii),
    .err_overrun    (err_overrun),
    .dbg_state      (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- upstream receiver model ----------------
  logic [7:0] up_mem [0:255];
  int up_wr = 0;
  int up_rd = 0;

  assign kbd_ready = (up_wr != up_rd);
  assign kbd_data  = kbd_ready ? up_mem[up_rd[7:0]] : 8'h00;

  always @(posedge clock) begin
    if (!clrn) begin
      up_rd <= up_wr;
    end else if (!kbd_nextdata_n) begin
      check("pop_from_nonempty", {31'd0, kbd_ready}, 32'd1);
      up_rd <= up_rd + 1;
    end
  end

  // ---------------- reference model ----------------
  logic [17:0] exp_q [$];
  logic m_ext = 1'b0;
  logic m_brk = 1'b0;
  int   m_pause = 0;
  logic m_ovr = 1'b0;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                   8'h3D, 8'h3E, 8'h46};
  logic [7:0] misc_codes [6]   = '{8'h29, 8'h5A, 8'h75, 8'h6B, 8'h66, 8'h76};

  function automatic logic [7:0] ascii_of(input logic [9:0] ev);
    if (ev[9:8] != 2'b00) return 8'h00;
    for (int i = 0; i < 26; i++) if (ev[7:0] == letter_codes[i]) return 8'h61 + i[7:0];
    for (int i = 0; i < 10; i++) if (ev[7:0] == digit_codes[i]) return 8'h30 + i[7:0];
    if (ev[7:0] == 8'h29) return 8'h20;
    if (ev[7:0] == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  function automatic void exp_push(input logic [9:0] ev);
    logic [7:0] a;
    a = 8'h00;
`ifdef PS2_DEC_ASCII_EN
    a = ascii_of(ev);
`endif
    exp_q.push_back({a, ev});
  endfunction

  // Directed expectation with a literal ASCII value for the enabled build.
  function automatic void exp_lit(input logic [9:0] ev, input logic [7:0] ascii_en);
    logic [7:0] a;
    a = 8'h00;
`ifdef PS2_DEC_ASCII_EN
    a = ascii_en;
`endif
    exp_q.push_back({a, ev});
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) exp_push(10'h0E1);
    end else if (b == 8'hE1) m_pause = 7;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'h00 || b == 8'hFF) m_ovr = 1'b1;
    else if ((b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE}) && !m_ext && !m_brk) begin
      // status byte, dropped
    end else begin
      exp_push({m_brk, m_ext, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_pause = 0;
    m_ovr = 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  int ready_mode = 1; // 0: held low, 1: held high, 2: random

  initial begin
    evt_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (ready_mode)
        0:       evt_ready = 1'b0;
        1:       evt_ready = 1'b1;
        default: evt_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic push_raw(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clock);
    while ((up_wr - up_rd) >= 8 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 1000) check("upstream_drain_timeout", 32'd1, 32'd0);
    up_mem[up_wr[7:0]] = b;
    up_wr++;
  endtask

  task automatic push_byte(input logic [7:0] b);
    push_raw(b);
    model_byte(b);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || up_wr != up_rd || evt_valid || dbg_state) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("drain_within_budget", {31'd0, n < budget}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic prev_n = 1'b1;

  always @(negedge clock) begin
    if (!kbd_nextdata_n) check("strobe_one_cycle", {31'd0, prev_n}, 32'd1);
    prev_n = kbd_nextdata_n;
    if (clrn && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %0h expected none", evt_data);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check("evt_data", {22'd0, evt_data}, {22'd0, e[9:0]});
        check("evt_ascii", {24'd0, evt_ascii}, {24'd0, e[17:10]});
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] b;
    int r;
    int n;
    logic held;

    // Reset state
    idle(2);
    check("rst_nextdata_n", {31'd0, kbd_nextdata_n}, 32'd1);
    check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_evt_data", {22'd0, evt_data}, 32'd0);
    check("rst_err_overrun", {31'd0, err_overrun}, 32'd0);
    check("rst_evt_ascii", {24'd0, evt_ascii}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    clrn = 1'b1;
    ready_mode = 1;
    idle(2);

    // Make / break of 'a', plus first-event latency
    push_raw(8'h1C);
    exp_lit(10'h01C, 8'h61);
    @(negedge clock);
    check("latency_edge1_valid", {31'd0, evt_valid}, 32'd0);
    @(negedge clock);
    check("latency_edge2_valid", {31'd0, evt_valid}, 32'd1);
    push_raw(8'hF0);
    push_raw(8'h1C);
    exp_lit(10'h21C, 8'h00);
    wait_drain(200);

    // Prefixes in either order
    push_raw(8'hE0); push_raw(8'hF0); push_raw(8'h75);
    exp_lit(10'h375, 8'h00);
    push_raw(8'hF0); push_raw(8'hE0); push_raw(8'h75);
    exp_lit(10'h375, 8'h00);
    wait_drain(200);

    // Pause sequence, status bytes and overrun
    push_raw(8'hE1); push_raw(8'h14); push_raw(8'h77); push_raw(8'hE1);
    push_raw(8'hF0); push_raw(8'h14); push_raw(8'hF0); push_raw(8'h77);
    exp_lit(10'h0E1, 8'h00);
    wait_drain(300);
    check("overrun_before", {31'd0, err_overrun}, 32'd0);
    push_raw(8'hFA); push_raw(8'hAA); push_raw(8'hFF);
    wait_drain(200);
    check("overrun_set", {31'd0, err_overrun}, 32'd1);
    m_ovr = 1'b1;

    // Backpressure: six make codes into a four-deep FIFO
    ready_mode = 0;
    idle(3);
    push_byte(8'h15); push_byte(8'h1D); push_byte(8'h24);
    push_byte(8'h2D); push_byte(8'h2C); push_byte(8'h35);
    idle(30);
    check("bp_upstream_left", up_wr - up_rd, 32'd2);
    check("bp_evt_valid", {31'd0, evt_valid}, 32'd1);
    held = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (!kbd_nextdata_n || dbg_state) held = 1'b0;
    end
    check("bp_strobe_held", {31'd0, held}, 32'd1);
    ready_mode = 1;
    wait_drain(300);

    // Randomized byte stream against the model
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      b = letter_codes[$urandom_range(0, 25)];
      else if (r < 42) b = digit_codes[$urandom_range(0, 9)];
      else if (r < 52) b = misc_codes[$urandom_range(0, 5)];
      else if (r < 64) b = 8'hE0;
      else if (r < 76) b = 8'hF0;
      else if (r < 79) b = 8'hE1;
      else if (r < 88) begin
        case ($urandom_range(0, 3))
          0:       b = 8'hFA;
          1:       b = 8'hAA;
          2:       b = 8'hEE;
          default: b = 8'hFE;
        endcase
      end else if (r < 90) b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      else b = 8'($urandom_range(0, 255));
      push_byte(b);
      idle($urandom_range(0, 2));
    end
    // Flush any pending pause/prefix so the decoder ends in a clean state.
    repeat (8) push_byte(8'h1C);
    wait_drain(3000);
    check("overrun_sticky", {31'd0, err_overrun}, {31'd0, m_ovr});

    // Reset in the middle of a POP with two events queued
    ready_mode = 0;
    idle(3);
    push_raw(8'h15); push_raw(8'h16); push_raw(8'hE0); push_raw(8'hF0); push_raw(8'h24);
    n = 0;
    while (!(kbd_nextdata_n == 1'b0 && (up_wr - up_rd) == 1) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("reach_last_pop", {31'd0, n < 100}, 32'd1);
    check("pre_rst_valid", {31'd0, evt_valid}, 32'd1);
    clrn = 1'b0;
    #1;
    check("async_rst_nextdata_n", {31'd0, kbd_nextdata_n}, 32'd1);
    check("async_rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("async_rst_evt_data", {22'd0, evt_data}, 32'd0);
    check("async_rst_overrun", {31'd0, err_overrun}, 32'd0);
    check("async_rst_state", {31'd0, dbg_state}, 32'd0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    clrn = 1'b1;
    ready_mode = 1;
    push_raw(8'h1C);
    exp_lit(10'h01C, 8'h61);
    wait_drain(200);
    check("post_rst_overrun", {31'd0, err_overrun}, 32'd0);

    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 Parameter EVT_DEPTH, default 4, event FIFO depth; SHALL be a power of two, 2..16.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 clrn  input  1  asynchronous active-low reset.
REQ-004 kbd_data  input  8  head byte of the upstream PS/2 receive FIFO.
REQ-005 kbd_ready  input  1  upstream FIFO non-empty.
REQ-006 kbd_nextdata_n  output  1  registered active-low pop strobe to the upstream receiver.
REQ-007 evt_valid  output  1  event FIFO non-empty.
REQ-008 evt_ready  input  1  consumer accepts the head event.
REQ-009 evt_data  output  10  head event {brk, ext, code[7:0]}.
REQ-010 evt_ascii  output  8  ASCII of the head event (see Configuration).
REQ-011 err_overrun  output  1  sticky flag: keyboard reported buffer overrun.

Function
REQ-012 FSM states IDLE, POP; IDLE->POP when kbd_ready=1 and the event FIFO is not full; POP->IDLE unconditionally after one cycle.
REQ-013 On IDLE->POP: byte register captures kbd_data, and kbd_nextdata_n SHALL be 0 for exactly the POP cycle, 1 at all other times.
REQ-014 Captured byte SHALL be decoded during POP; any resulting event is written at the POP->IDLE edge, so evt_valid rises 2 cycles after kbd_ready is sampled with an empty FIFO.
REQ-015 Byte 0xE0: set ext prefix flag, no event; byte 0xF0: set brk prefix flag, no event; flags set in either order.
REQ-016 Byte 0xE1 with pause counter 0: load pause counter 7, no event; while counter nonzero each byte decrements it and is discarded; byte bringing it to 0 pushes event {0,0,8'hE1}.
REQ-017 Bytes 0xFA, 0xAA, 0xEE, 0xFE with no prefix pending: discarded, no event; 0x00 or 0xFF: discarded, err_overrun set to 1.
REQ-018 Any other byte: push {brk, ext, byte}, then clear both prefix flags.
REQ-019 Event FIFO: push on write strobe, pop when evt_valid and evt_ready; simultaneous push and pop SHALL leave occupancy unchanged; pointers wrap modulo EVT_DEPTH.
REQ-020 Full FIFO SHALL hold the FSM in IDLE (backpressure into the upstream receiver); no byte SHALL be dropped by this block.
REQ-021 evt_ready while evt_valid=0 SHALL have no effect.
REQ-022 err_overrun SHALL clear only on reset.

Reset
REQ-023 clrn=0 SHALL immediately force: state IDLE, kbd_nextdata_n=1, FIFO empty, evt_valid=0, evt_data=0, prefix flags 0, pause counter 0, err_overrun=0.
REQ-024 Reset asserted during POP SHALL discard the captured byte and return kbd_nextdata_n to 1 without waiting for a clock edge.

Configuration
REQ-025 Macro PS2_DEC_ASCII_EN defined: evt_ascii SHALL be a combinational set-2 lookup of the head event for ext=0, brk=0 codes of letters (lowercase), digits, space 0x29->0x20, enter 0x5A->0x0D; all else 0x00.
REQ-026 Macro PS2_DEC_ASCII_EN undefined: no lookup logic is built; evt_ascii SHALL be constant 0x00.

Verification
REQ-027 Bytes 0x1C, 0xF0, 0x1C with evt_ready=1 -> events 0x01C, then 0x21C; each kbd_nextdata_n pulse exactly one cycle wide.
REQ-028 Bytes 0xE0, 0xF0, 0x75 -> single event 0x375; bytes 0xF0, 0xE0, 0x75 -> same event 0x375.
REQ-029 EVT_DEPTH=4, evt_ready=0, six make codes queued upstream -> four events held, kbd_nextdata_n stays 1 after the fourth pop; release evt_ready -> remaining two delivered in order.
REQ-030 Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event 0x0E1; 0xFA, 0xAA, 0xFF -> no events, err_overrun=1.
REQ-031 clrn pulsed low mid-POP with two events queued -> evt_valid=0, kbd_nextdata_n=1 asynchronously; next byte 0x1C decodes as 0x01C (no stale prefix).
REQ-032 With PS2_DEC_ASCII_EN: head 0x01C -> evt_ascii 0x61, head 0x21C -> 0x00; without macro: evt_ascii 0x00 for both.
